// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DefaultAddrW   = 16;
  localparam int unsigned DefaultLatency = 4;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory stage (master) and the responder (slave).
interface data_mem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
);

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  word_t             req_wdata;
  logic              busy;
  logic              resp_valid;
  word_t             resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  busy, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output busy, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one asynchronous read port. Never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-2:0] waddr,
  input  word_t             wdata,
  input  logic [ADDR_W-2:0] raddr,
  output word_t             rdata
);

  localparam int unsigned Depth = 1 << (ADDR_W - 1);

  word_t mem [Depth];

  // Commit a write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: IDLE -> WAIT -> RESP with registered outputs.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned LATENCY = DefaultLatency  // legal 2..15
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-2:0] idx_q;
  word_t             wdata_q;
  logic              err_q;
  logic              busy_q;
  logic              resp_valid_q;
  word_t             resp_rdata_q;
  word_t             arr_rdata;
  logic              arr_we;

  // Commit only at the end of RESP; a reset on that edge abandons the store.
  assign arr_we = (state_q == RESP) && we_q && !err_q && !rst;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(idx_q),
    .rdata(arr_rdata)
  );

`ifdef DMEM_ALIGN_CHK_EN
  logic resp_err_q;

  // Error flag pulses alongside resp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= (state_q == WAIT) && (cnt_q == 4'd1) && err_q;
    end
  end

  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  // Main FSM, latency counter, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_q <= WAIT;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            we_q    <= bus.req_we;
            idx_q   <= bus.req_addr[ADDR_W-1:1];
            wdata_q <= bus.req_wdata;
`ifdef DMEM_ALIGN_CHK_EN
            err_q   <= bus.req_addr[0];
`else
            err_q   <= 1'b0;
`endif
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            // Stores and rejected accesses return zero; loads sample the array now.
            resp_rdata_q <= (we_q || err_q) ? 16'h0000 : arr_rdata;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
